// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op width for the sequential ALU.
// Imported by alu_muldiv_seq and muldiv_iter.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULTU = 4'b1000,
    OP_DIVU  = 4'b1001,
    OP_MULT  = 4'b1010,
    OP_DIV   = 4'b1011
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 1 bit/cycle engine: shift-add multiply, restoring divide.
// lo/hi expose the value the current iteration produces; valid with done.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] opnd;
  logic             div;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] nxt_acc;
  logic [WIDTH-1:0] nxt_quo;

  // acc is the high half / partial remainder, quo the low half / quotient
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, opnd};
    sh   = {acc, quo[WIDTH-1]};
    diff = sh - {1'b0, opnd};
    nxt_acc = '0;
    nxt_quo = '0;
    if (div) begin
      if (sh >= {1'b0, opnd}) begin
        nxt_acc = diff[WIDTH-1:0];
        nxt_quo = {quo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc = sh[WIDTH-1:0];
        nxt_quo = {quo[WIDTH-2:0], 1'b0};
      end
    end else if (quo[0]) begin
      nxt_acc = sum[WIDTH:1];
      nxt_quo = {sum[0], quo[WIDTH-1:1]};
    end else begin
      nxt_acc = {1'b0, acc[WIDTH-1:1]};
      nxt_quo = {acc[0], quo[WIDTH-1:1]};
    end
  end

  assign done = busy && (cnt == CNT_W'(1));
  assign lo   = nxt_quo;
  assign hi   = nxt_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      quo  <= '0;
      opnd <= '0;
      div  <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(WIDTH);
      acc  <= '0;
      quo  <= a;
      opnd <= b;
      div  <= is_div;
    end else if (busy) begin
      acc <= nxt_acc;
      quo <= nxt_quo;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Handshaked ALU with iterative mul/div; FSM, flags and single-cycle path.
// ALU_SIGNED_MULDIV_EN enables signed MULT/DIV through the same engine.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    src_a,
  input  logic [WIDTH-1:0]    src_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic [WIDTH-1:0]    hi,
  output logic                zero,
  output logic                div_by_zero,
  output logic                illegal_op
);

  state_t state;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] alu_hi;
  logic             ill_d;
  logic             dbz_d;
  logic             start_op;
  logic             is_div;
  logic [WIDTH-1:0] eng_a;
  logic [WIDTH-1:0] eng_b;
  logic             accept;

  logic             eng_busy;
  logic             eng_done;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] fin_lo;
  logic [WIDTH-1:0] fin_hi;

`ifdef ALU_SIGNED_MULDIV_EN
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_prod_d;
  logic             neg_q_d;
  logic             neg_r_d;
  logic             neg_prod;
  logic             neg_q;
  logic             neg_r;
  logic [2*WIDTH-1:0] prod;

  assign sa    = src_a[WIDTH-1];
  assign sb    = src_b[WIDTH-1];
  assign mag_a = sa ? -src_a : src_a;
  assign mag_b = sb ? -src_b : src_b;
`endif

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_res  = '0;
    alu_hi   = '0;
    ill_d    = 1'b0;
    dbz_d    = 1'b0;
    start_op = 1'b0;
    is_div   = 1'b0;
    eng_a    = src_a;
    eng_b    = src_b;
`ifdef ALU_SIGNED_MULDIV_EN
    neg_prod_d = 1'b0;
    neg_q_d    = 1'b0;
    neg_r_d    = 1'b0;
`endif
    case (op)
      OP_AND: alu_res = src_a & src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_ADD: alu_res = src_a + src_b;
      OP_XOR: alu_res = src_a ^ src_b;
      OP_SUB: alu_res = src_a - src_b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                         $signed(src_a) < $signed(src_b)};
      OP_MULTU: start_op = 1'b1;
      OP_DIVU: begin
        if (src_b == '0) begin
          dbz_d   = 1'b1;
          alu_res = '1;
          alu_hi  = src_a;
        end else begin
          start_op = 1'b1;
          is_div   = 1'b1;
        end
      end
`ifdef ALU_SIGNED_MULDIV_EN
      OP_MULT: begin
        start_op   = 1'b1;
        eng_a      = mag_a;
        eng_b      = mag_b;
        neg_prod_d = sa ^ sb;
      end
      OP_DIV: begin
        if (src_b == '0) begin
          dbz_d   = 1'b1;
          alu_res = '1;
          alu_hi  = src_a;
        end else begin
          start_op = 1'b1;
          is_div   = 1'b1;
          eng_a    = mag_a;
          eng_b    = mag_b;
          neg_q_d  = sa ^ sb;
          neg_r_d  = sa;
        end
      end
`endif
      default: ill_d = 1'b1;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && start_op),
    .is_div (is_div),
    .a      (eng_a),
    .b      (eng_b),
    .busy   (eng_busy),
    .done   (eng_done),
    .lo     (eng_lo),
    .hi     (eng_hi)
  );

`ifdef ALU_SIGNED_MULDIV_EN
  // Sign correction rides on the last iteration, so latency is unchanged
  always_comb begin
    prod = {eng_hi, eng_lo};
    if (neg_prod) prod = -prod;
    fin_lo = prod[WIDTH-1:0];
    fin_hi = prod[2*WIDTH-1:WIDTH];
    if (neg_q) fin_lo = -eng_lo;
    if (neg_r) fin_hi = -eng_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_prod <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (accept) begin
      neg_prod <= neg_prod_d;
      neg_q    <= neg_q_d;
      neg_r    <= neg_r_d;
    end
  end
`else
  assign fin_lo = eng_lo;
  assign fin_hi = eng_hi;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      hi          <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (start_op) begin
              state <= BUSY;
            end else begin
              state       <= DONE;
              out_valid   <= 1'b1;
              result      <= alu_res;
              hi          <= alu_hi;
              zero        <= (alu_res == '0);
              div_by_zero <= dbz_d;
              illegal_op  <= ill_d;
            end
          end
        end
        BUSY: begin
          if (eng_busy && eng_done) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            result      <= fin_lo;
            hi          <= fin_hi;
            zero        <= (fin_lo == '0);
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed vector bench for alu_muldiv_seq (WIDTH=32).
// Signed vectors are added when ALU_SIGNED_MULDIV_EN is defined.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = 4'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic         zero;
  logic         div_by_zero;
  logic         illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .hi          (hi),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         dbz;
    logic         ill;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [3:0] o,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic [W-1:0] h,
                              input logic z, input logic d, input logic i,
                              input int l);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b;
    v.res = r; v.hi = h; v.z = z; v.dbz = d; v.ill = i; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, return latency from accept edge to out_valid
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat,
                       output logic busy_blocked);
    @(negedge clk);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    busy_blocked = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_blocked = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_drain_valid"}, W'(out_valid), W'(0));
    chk({name, "_drain_flags"}, W'({div_by_zero, illegal_op}), W'(0));
  endtask

  initial begin
    int lat;
    logic blk;
    logic [W-1:0] held_res;

    vecs.push_back(mk("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1,
                      32'h80000000, 0, 0, 0, 0, 1));
    vecs.push_back(mk("sub_zero", OP_SUB, 32'd5, 32'd5, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk("slt_neg", OP_SLT, 32'hFFFFFFFF, 32'd1,
                      32'd1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("slt_pos", OP_SLT, 32'd1, 32'hFFFFFFFF,
                      0, 0, 1, 0, 0, 1));
    vecs.push_back(mk("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00,
                      32'hF000F000, 0, 0, 0, 0, 1));
    vecs.push_back(mk("or", OP_OR, 32'h0F0F0000, 32'h000000FF,
                      32'h0F0F00FF, 0, 0, 0, 0, 1));
    vecs.push_back(mk("xor", OP_XOR, 32'hAAAAAAAA, 32'hFFFFFFFF,
                      32'h55555555, 0, 0, 0, 0, 1));
    vecs.push_back(mk("sub_wrap", OP_SUB, 0, 32'd1,
                      32'hFFFFFFFF, 0, 0, 0, 0, 1));
    vecs.push_back(mk("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'd1,
                      0, 0, 1, 0, 0, 1));
    vecs.push_back(mk("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                      32'h1, 32'hFFFFFFFE, 0, 0, 0, 33));
    vecs.push_back(mk("multu_mid", OP_MULTU, 32'h00012345, 32'h00010000,
                      32'h23450000, 32'h1, 0, 0, 0, 33));
    vecs.push_back(mk("multu_zero", OP_MULTU, 0, 32'd5, 0, 0, 1, 0, 0, 33));
    vecs.push_back(mk("divu_100_7", OP_DIVU, 32'd100, 32'd7,
                      32'd14, 32'd2, 0, 0, 0, 33));
    vecs.push_back(mk("divu_small", OP_DIVU, 32'd3, 32'd10,
                      0, 32'd3, 1, 0, 0, 33));
    vecs.push_back(mk("divu_max", OP_DIVU, 32'hFFFFFFFF, 32'd1,
                      32'hFFFFFFFF, 0, 0, 0, 0, 33));
    vecs.push_back(mk("divu_by0", OP_DIVU, 32'd9, 0,
                      32'hFFFFFFFF, 32'd9, 0, 1, 0, 1));
    vecs.push_back(mk("ill_0101", 4'b0101, 32'd3, 32'd4, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk("ill_1111", 4'b1111, 32'd3, 32'd4, 0, 0, 1, 0, 1, 1));
`ifdef ALU_SIGNED_MULDIV_EN
    vecs.push_back(mk("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2,
                      32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, 33));
    vecs.push_back(mk("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
                      32'h80000000, 0, 0, 0, 0, 33));
    vecs.push_back(mk("div_by0_s", OP_DIV, 32'hFFFFFFF9, 0,
                      32'hFFFFFFFF, 32'hFFFFFFF9, 0, 1, 0, 1));
    vecs.push_back(mk("mult_m3_5", OP_MULT, 32'hFFFFFFFD, 32'd5,
                      32'hFFFFFFF1, 32'hFFFFFFFF, 0, 0, 0, 33));
    vecs.push_back(mk("mult_m2_m2", OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFE,
                      32'd4, 0, 0, 0, 0, 33));
`else
    vecs.push_back(mk("ill_mult", 4'b1010, 32'd3, 32'd4, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk("ill_div", 4'b1011, 32'd8, 32'd2, 0, 0, 1, 0, 1, 1));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_flags", W'({zero, div_by_zero, illegal_op}), W'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", W'(in_ready), W'(1));

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, blk);
      chk({vecs[i].name, "_lat"}, W'(lat), W'(vecs[i].lat));
      chk({vecs[i].name, "_res"}, result, vecs[i].res);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      chk({vecs[i].name, "_zero"}, W'(zero), W'(vecs[i].z));
      chk({vecs[i].name, "_dbz"}, W'(div_by_zero), W'(vecs[i].dbz));
      chk({vecs[i].name, "_ill"}, W'(illegal_op), W'(vecs[i].ill));
      chk({vecs[i].name, "_ready"}, W'(in_ready), W'(0));
      if (vecs[i].lat > 1)
        chk({vecs[i].name, "_busy_blk"}, W'(blk), W'(1));
      drain(vecs[i].name);
    end

    // Backpressure: outputs hold while a second request is offered
    issue(OP_XOR, 32'h12345678, 32'h0000FFFF, lat, blk);
    held_res = 32'h1234A987;
    chk("bp_res0", result, held_res);
    @(negedge clk);
    op = OP_ADD; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_res", result, held_res);
      chk("bp_hi", hi, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("bp");

    // Reset while an unsigned multiply is in flight
    issue(OP_ADD, 32'd2, 32'd3, lat, blk);
    chk("pre_rst_res", result, 32'd5);
    drain("pre_rst");
    @(negedge clk);
    op = OP_MULTU; src_a = 32'd7; src_b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy_ready", W'(in_ready), W'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", W'(out_valid), W'(0));
    chk("abort_result", result, 0);
    chk("abort_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", W'(out_valid), W'(0));

    issue(OP_MULTU, 32'd7, 32'd9, lat, blk);
    chk("post_rst_lat", W'(lat), W'(33));
    chk("post_rst_res", result, 32'd63);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
